imm_encoder: RTL
================

Name: imm_encoder

Overview:
- Inverse of the core's immediate decode path: packs an instruction-format code, opcode/funct/register fields and a 64-bit immediate into a 32-bit RV64 instruction word.
- Checks that the immediate is representable in the chosen format and flags it if not.
- Used by the self-test instruction generator and the trace re-assembler to feed instruction memory.
- Streaming block: valid/ready input, 2-entry output buffer, running counters.

Parameters:
- CNT_W, 16, width of the encoded-instruction and error counters.
- NOP_INST, 32'h00000013, word emitted for an illegal format code.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request this cycle.
- in_fmt  input  3  format code: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are illegal.
- in_opcode  input  7  opcode, placed in inst[6:0].
- in_funct3  input  3  funct3 field.
- in_funct7  input  7  funct7 field, R format only.
- in_rd, in_rs1, in_rs2  input  5 each  register fields.
- in_imm  input  64  signed byte immediate.
- out_valid  output  1  encoded word available.
- out_ready  input  1  consumer accepts the word.
- out_inst  output  32  encoded instruction.
- out_err  output  1  immediate not representable, or illegal format code.
- enc_count  output  CNT_W  count of words accepted at the output.
- err_count  output  CNT_W  count of output words with err set.

Behaviour:
- Clocking and reset: one clock (clk); asynchronous active-low reset (rst_n).
- Reset values: all outputs 0 except in_ready=1. Buffer is emptied and counters cleared. Any in-flight request is discarded.
- Input handshake:
  - Accept when in_valid && in_ready.
  - in_ready = (buffer count < 2), taken from registered state only. It stays 0 at count 2 even when out_ready=1 in that cycle.
- Latency: a word accepted in cycle N is at the buffer head, with out_valid=1, from cycle N+1 if the buffer was empty.
- Buffer:
  - 2-entry FIFO of {inst, err}; output order equals input order.
  - Simultaneous push and pop at count 1 leaves count at 1.
  - out_valid = (count != 0).
  - out_inst and out_err must hold stable while out_valid && !out_ready.
- Field placement by format:
  - R: {funct7, rs2, rs1, funct3, rd, opcode}.
  - I: {imm[11:0], rs1, funct3, rd, opcode}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
  - U: {imm[31:12], rd, opcode}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
- Range checks (err=1 on failure; the word is still emitted from the truncated bits):
  - R: never errors; in_imm is ignored.
  - I and S: imm[63:11] all equal.
  - B: imm[63:12] all equal, and imm[0]=0.
  - U: imm[63:31] all equal, and imm[11:0]=0.
  - J: imm[63:20] all equal, and imm[0]=0.
- Illegal fmt (6 or 7): inst=NOP_INST, err=1.
- Counters:
  - enc_count increments on each out_valid && out_ready and wraps modulo 2^CNT_W.
  - err_count increments on the same event when the popped entry has err=1, and saturates at all-ones.

Decomposition:
- Shared package imm_enc_pkg holds:
  - format-code localparams (FMT_R..FMT_J);
  - standard opcode constants (OP_IMM, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR);
  - NOP_INST.
- One sub-module, inst_pack: purely combinational field packing plus range check. Output {inst, err}.
- The top level holds the 2-entry FIFO, the handshake logic and the counters.

Test Plan:
- I-type: fmt=1, op=0010011, rd=1, rs1=0, f3=0, imm=64'hFFFF_FFFF_FFFF_FFFF, out_ready=1 -> next cycle out_inst=32'hFFF00093, out_err=0, enc_count=1.
- S-type: fmt=2, op=0100011, f3=010, rs1=3, rs2=2, imm=8 -> 32'h0021A423, err=0.
- B-type: fmt=3, op=1100011, f3=000, rs1=1, rs2=2, imm=-4 -> 32'hFE208EE3, err=0. Then the same request with imm=3 -> err=1 and err_count=1.
- U-type then J-type:
  - fmt=4, op=0110111, rd=5, imm=32'h12345000 -> 32'h123452B7.
  - fmt=5, op=1101111, rd=1, imm=2048 -> 32'h001000EF.
- Backpressure:
  - out_ready=0 with 3 back-to-back requests -> in_ready=0 after the 2nd accept; out_inst stays stable.
  - Raise out_ready -> both words pop in order, then in_ready=1.
  - fmt=7 -> out_inst=32'h00000013, err=1.
- Reset mid-operation: rst_n low while the buffer holds 2 entries -> out_valid=0, counters=0, in_ready=1 immediately. After release, the first new request is encoded correctly.

Source files
------------

// File: rtl/imm_enc_pkg.sv
// Shared constants and types for the RV64 immediate encoder.
// Format codes, standard opcodes and the buffered {inst, err} entry live here.
package imm_enc_pkg;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;

  localparam logic [31:0] NOP_INST = 32'h00000013;

  typedef struct packed {
    logic [31:0] inst;
    logic        err;
  } enc_entry_t;

  // True when every bit from msb up to bit 63 matches the sign bit,
  // i.e. the value survives truncation to msb+1 bits as a signed number.
  function automatic logic upper_uniform(input logic [63:0] imm, input int msb);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (i >= msb && imm[i] != imm[63]) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/inst_pack.sv
// Combinational field packer: places opcode/register/immediate fields for one
// RV64 format and flags immediates that do not fit that format.
module inst_pack
  import imm_enc_pkg::*;
#(
  parameter logic [31:0] NOP_INST = imm_enc_pkg::NOP_INST
) (
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [63:0] imm,
  output logic [31:0] inst,
  output logic        err
);

  // Illegal format codes fall through to the NOP with err raised.
  always_comb begin
    inst = NOP_INST;
    err  = 1'b1;
    case (fmt)
      FMT_R: begin
        inst = {funct7, rs2, rs1, funct3, rd, opcode};
        err  = 1'b0;
      end
      FMT_I: begin
        inst = {imm[11:0], rs1, funct3, rd, opcode};
        err  = !upper_uniform(imm, 11);
      end
      FMT_S: begin
        inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        err  = !upper_uniform(imm, 11);
      end
      FMT_B: begin
        inst = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        err  = !upper_uniform(imm, 12) || imm[0];
      end
      FMT_U: begin
        inst = {imm[31:12], rd, opcode};
        err  = !upper_uniform(imm, 31) || (imm[11:0] != 12'h000);
      end
      FMT_J: begin
        inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        err  = !upper_uniform(imm, 20) || imm[0];
      end
      default: begin
        inst = NOP_INST;
        err  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// Streaming RV64 instruction encoder: valid/ready input, 2-entry output FIFO of
// {inst, err}, and running counts of emitted words and erroneous words.
module imm_encoder
  import imm_enc_pkg::*;
#(
  parameter int          CNT_W    = 16,
  parameter logic [31:0] NOP_INST = imm_enc_pkg::NOP_INST
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_fmt,
  input  logic [6:0]       in_opcode,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [63:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);

  enc_entry_t mem [2];
  enc_entry_t packed_entry;
  logic [1:0] count;
  logic       wr_ptr;
  logic       rd_ptr;
  logic       push;
  logic       pop;

  inst_pack #(.NOP_INST(NOP_INST)) u_pack (
    .fmt    (in_fmt),
    .opcode (in_opcode),
    .funct3 (in_funct3),
    .funct7 (in_funct7),
    .rd     (in_rd),
    .rs1    (in_rs1),
    .rs2    (in_rs2),
    .imm    (in_imm),
    .inst   (packed_entry.inst),
    .err    (packed_entry.err)
  );

  // in_ready looks only at the registered fill level, so a full buffer refuses
  // a request even in the cycle it is being drained.
  assign in_ready  = (count < 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_inst  = mem[rd_ptr].inst;
  assign out_err   = mem[rd_ptr].err;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) mem[i] <= '0;
      count     <= 2'd0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      enc_count <= '0;
      err_count <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= packed_entry;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr    <= ~rd_ptr;
        enc_count <= enc_count + 1'b1;
        if (mem[rd_ptr].err && (err_count != {CNT_W{1'b1}})) begin
          err_count <= err_count + 1'b1;
        end
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule
